// File: rtl/key_loader_schedule_sequencer_if.sv
// Key word handshake between the key source and the loader.
interface key_loader_schedule_sequencer_if #(
   parameter int unsigned NB_DATA = 32
) ();
   logic [NB_DATA-1:0] i_data;
   logic               i_data_valid;
   logic               o_data_ready;

   modport master (output i_data, output i_data_valid, input o_data_ready);
   modport slave  (input i_data, input i_data_valid, output o_data_ready);
endinterface

// File: rtl/key_loader_schedule_sequencer.sv
// Assembles a cipher key from a word stream, triggers the AES-256 key scheduler and flags when
// the round-key vector is stable. Optional macro KEY_LOADER_ZEROIZE_EN clears stale key material.
module key_loader_schedule_sequencer #(
   parameter int unsigned NB_BYTE       = 8,
   parameter int unsigned N_BYTES_KEY   = 32,
   parameter int unsigned NB_DATA       = 32,
   parameter int unsigned N_ROUNDS      = 14,
   parameter int unsigned SCHED_LATENCY = N_ROUNDS - 1
) (
   input  logic                            i_clock,
   input  logic                            i_reset_n,
   input  logic                            i_valid,
   input  logic                            i_flush,
   key_loader_schedule_sequencer_if.slave  key_bus,
   output logic [N_BYTES_KEY*NB_BYTE-1:0]  o_key,
   output logic                            o_trigger_schedule,
   output logic                            o_keys_ready,
   output logic                            o_busy
);
   localparam int unsigned KeyW        = N_BYTES_KEY * NB_BYTE;
   localparam int unsigned N_KEY_WORDS = KeyW / NB_DATA;
   localparam int unsigned CntW        = (N_KEY_WORDS > 1) ? $clog2(N_KEY_WORDS) : 1;
   localparam int unsigned WaitW       = $clog2(SCHED_LATENCY + 1);

   typedef enum logic [1:0] {StLoad, StTrigger, StWait, StDone} state_t;

   state_t            state_q, state_d;
   logic [CntW-1:0]   word_cnt_q, word_cnt_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [KeyW-1:0]   key_q, key_d, key_base;
   logic              keys_ready_q, keys_ready_d;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q      <= StLoad;
         word_cnt_q   <= '0;
         wait_cnt_q   <= '0;
         key_q        <= '0;
         keys_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_cnt_q   <= word_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         key_q        <= key_d;
         keys_ready_q <= keys_ready_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_cnt_d   = word_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      key_d        = key_q;
      keys_ready_d = keys_ready_q;
      key_base     = key_q;
      if (i_valid) begin
         if (i_flush) begin
            // Flush wins over a coincident accept; the word is dropped.
            state_d    = StLoad;
            word_cnt_d = '0;
            if (state_q == StTrigger || state_q == StWait) keys_ready_d = 1'b0;
`ifdef KEY_LOADER_ZEROIZE_EN
            key_d = '0;
`endif
         end else begin
            unique case (state_q)
               StLoad, StDone: begin
                  if (key_bus.i_data_valid) begin
`ifdef KEY_LOADER_ZEROIZE_EN
                     if (state_q == StDone) key_base = '0;
`endif
                     key_d = {key_base[KeyW-NB_DATA-1:0], key_bus.i_data};
                     // word_cnt_q is always 0 in DONE, so a DONE accept counts as word 1.
                     if (word_cnt_q == CntW'(N_KEY_WORDS - 1)) begin
                        word_cnt_d = '0;
                        state_d    = StTrigger;
                     end else begin
                        word_cnt_d = word_cnt_q + CntW'(1);
                        state_d    = StLoad;
                     end
                  end
               end
               StTrigger: begin
                  state_d      = StWait;
                  wait_cnt_d   = '0;
                  keys_ready_d = 1'b0;
               end
               StWait: begin
                  wait_cnt_d = wait_cnt_q + WaitW'(1);
                  if (wait_cnt_q == WaitW'(SCHED_LATENCY - 1)) begin
                     state_d      = StDone;
                     keys_ready_d = 1'b1;
                  end
               end
               default: state_d = StLoad;
            endcase
         end
      end
   end

   always_comb begin
      o_trigger_schedule   = (state_q == StTrigger);
      o_busy               = (state_q == StTrigger) || (state_q == StWait);
      key_bus.o_data_ready = (state_q == StLoad) || (state_q == StDone);
   end

   assign o_key        = key_q;
   assign o_keys_ready = keys_ready_q;
endmodule

// File: tb/tb_key_loader_schedule_sequencer.sv
// Randomised self-checking bench for key_loader_schedule_sequencer against a phase-level model.
module tb_key_loader_schedule_sequencer;
   logic         i_clock = 1'b0;
   logic         i_reset_n;
   logic         i_valid;
   logic         i_flush;
   logic [255:0] o_key;
   logic         o_trigger_schedule;
   logic         o_keys_ready;
   logic         o_busy;

   key_loader_schedule_sequencer_if #(.NB_DATA(32)) kbus ();

   key_loader_schedule_sequencer dut (
      .i_clock            (i_clock),
      .i_reset_n          (i_reset_n),
      .i_valid            (i_valid),
      .i_flush            (i_flush),
      .key_bus            (kbus),
      .o_key              (o_key),
      .o_trigger_schedule (o_trigger_schedule),
      .o_keys_ready       (o_keys_ready),
      .o_busy             (o_busy)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int passes = 0;

   // Model phases: 0 load, 1 trigger, 2 wait, 3 done.
   int           m_phase;
   int           m_words;
   int           m_wait_left;
   logic [255:0] m_key;
   bit           m_kr;

   function automatic logic [3:0] m_flags();
      return {m_phase == 1, m_phase == 1 || m_phase == 2, m_kr, m_phase == 0 || m_phase == 3};
   endfunction

   function automatic logic [3:0] dut_flags();
      return {o_trigger_schedule, o_busy, o_keys_ready, kbus.o_data_ready};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_words = 0; m_wait_left = 0; m_key = '0; m_kr = 0;
   endtask

   // Drive one cycle of inputs, advance one edge and update the model.
   task automatic drive(input bit v, input bit dv, input bit fl, input logic [31:0] d);
      int           ph = m_phase;
      int           w  = m_words;
      int           wl = m_wait_left;
      logic [255:0] k  = m_key;
      bit           kr = m_kr;
      i_valid = v; kbus.i_data_valid = dv; i_flush = fl; kbus.i_data = d;
      if (v) begin
         if (fl) begin
            if (ph == 1 || ph == 2) kr = 0;
            ph = 0; w = 0;
`ifdef KEY_LOADER_ZEROIZE_EN
            k = '0;
`endif
         end else if (ph == 0 || ph == 3) begin
            if (dv) begin
               if (ph == 3) begin
                  w = 0;
`ifdef KEY_LOADER_ZEROIZE_EN
                  k = '0;
`endif
               end
               k = {k[223:0], d};
               w++;
               if (w == 8) begin w = 0; ph = 1; end
               else ph = 0;
            end
         end else if (ph == 1) begin
            ph = 2; wl = 13; kr = 0;
         end else begin
            wl--;
            if (wl == 0) begin ph = 3; kr = 1; end
         end
      end
      @(posedge i_clock);
      #1;
      m_phase = ph; m_words = w; m_wait_left = wl; m_key = k; m_kr = kr;
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0; i_valid = 0; i_flush = 0; kbus.i_data_valid = 0; kbus.i_data = '0;
      model_reset();
      repeat (2) @(posedge i_clock);
      #1;
      checks++;
      if (dut_flags() !== 4'b0001) $display("FAIL reset_flags: got %b want 0001", dut_flags());
      else passes++;
      checks++;
      if (o_key !== '0) $display("FAIL reset_key: got %h want 0", o_key);
      else passes++;
      i_reset_n = 1'b1;
   endtask

   task automatic test_basic_load();
      int n = 0;
      int busy_cnt = 0;
      logic [255:0] exp_key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b = 8'(4 * i);
         drive(1, 1, 0, {b, b + 8'd1, b + 8'd2, b + 8'd3});
         checks++;
         if (dut_flags() !== m_flags())
            $display("FAIL basic_load word %0d: flags %b want %b", i, dut_flags(), m_flags());
         else passes++;
      end
      checks++;
      if ({o_trigger_schedule, o_busy} !== 2'b11)
         $display("FAIL basic_trigger_t1: trig/busy %b want 11", {o_trigger_schedule, o_busy});
      else passes++;
      if (o_busy) busy_cnt++;
      while (!o_keys_ready && n < 40) begin
         drive(1, 0, 0, $urandom);
         n++;
         if (o_busy) busy_cnt++;
      end
      checks++;
      if (n !== 14) $display("FAIL basic_latency: keys_ready after %0d edges want 14", n);
      else passes++;
      checks++;
      if (busy_cnt !== 14) $display("FAIL basic_busy_len: busy %0d cycles want 14", busy_cnt);
      else passes++;
      checks++;
      if (o_key !== exp_key) $display("FAIL basic_key: got %h want %h", o_key, exp_key);
      else passes++;
   endtask

   task automatic test_valid_toggle();
      for (int i = 0; i < 60; i++) begin
         drive(i % 2 == 0, 1'b1, 0, $urandom);
         checks++;
         if (dut_flags() !== m_flags() || o_key !== m_key)
            $display("FAIL valid_toggle cyc %0d: flags %b key %h want %b %h",
                     i, dut_flags(), o_key, m_flags(), m_key);
         else passes++;
      end
   endtask

   task automatic test_hold_dv();
      logic [31:0]  w [8];
      logic [255:0] exp_key;
      // Settle into DONE with no new words first.
      for (int i = 0; i < 40 && m_phase != 3; i++) drive(1, 0, 0, '0);
      for (int i = 0; i < 22; i++) begin
         logic [31:0] d = $urandom;
         if (i < 8) w[i] = d;
         drive(1, 1, 0, d);
         checks++;
         if (dut_flags() !== m_flags() || o_key !== m_key)
            $display("FAIL hold_dv cyc %0d: flags %b key %h want %b %h",
                     i, dut_flags(), o_key, m_flags(), m_key);
         else passes++;
      end
      for (int i = 0; i < 8; i++) exp_key[255 - 32 * i -: 32] = w[i];
      checks++;
      if (o_key !== exp_key || !o_keys_ready || o_busy)
         $display("FAIL hold_dv_final: key %h kr %b busy %b want %h 1 0",
                  o_key, o_keys_ready, o_busy, exp_key);
      else passes++;
   endtask

   task automatic test_flush();
      logic [31:0]  w [8];
      logic [255:0] exp_key;
      for (int i = 0; i < 5; i++) drive(1, 1, 0, $urandom);
      drive(1, 1, 1, $urandom);
      checks++;
      if (o_key !== m_key || dut_flags() !== m_flags())
         $display("FAIL flush_after5: key %h flags %b want %h %b",
                  o_key, dut_flags(), m_key, m_flags());
      else passes++;
      for (int i = 0; i < 8; i++) begin
         w[i] = $urandom;
         drive(1, 1, 0, w[i]);
      end
      for (int i = 0; i < 8; i++) exp_key[255 - 32 * i -: 32] = w[i];
      checks++;
      if (o_key !== exp_key || !o_trigger_schedule)
         $display("FAIL flush_fresh_key: key %h trig %b want %h 1",
                  o_key, o_trigger_schedule, exp_key);
      else passes++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 24) == 0, $urandom);
         checks++;
         if (dut_flags() !== m_flags() || o_key !== m_key)
            $display("FAIL random cyc %0d: flags %b key %h want %b %h",
                     i, dut_flags(), o_key, m_flags(), m_key);
         else passes++;
      end
   endtask

   task automatic test_async_reset();
      drive(1, 0, 1, '0);
      for (int i = 0; i < 8; i++) drive(1, 1, 0, $urandom);
      for (int i = 0; i < 6; i++) drive(1, 0, 0, '0);
      checks++;
      if (!o_busy || o_trigger_schedule)
         $display("FAIL areset_setup: busy %b trig %b want 1 0", o_busy, o_trigger_schedule);
      else passes++;
      #2;
      i_reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_flags() !== 4'b0001 || o_key !== '0)
         $display("FAIL areset_immediate: flags %b key %h want 0001 0", dut_flags(), o_key);
      else passes++;
      i_valid = 0;
      @(negedge i_clock);
      i_reset_n = 1'b1;
      @(posedge i_clock);
      #1;
      checks++;
      if (kbus.o_data_ready !== 1'b1 || o_keys_ready !== 1'b0)
         $display("FAIL areset_release: ready %b keys_ready %b want 1 0",
                  kbus.o_data_ready, o_keys_ready);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_valid_toggle();
      test_hold_dv();
      test_flush();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/key_loader_schedule_sequencer.md
Name: key_loader_schedule_sequencer

Overview:
- Sits directly upstream of the AES-256 key scheduler.
- Collects a cipher key over a narrow valid/ready word interface and assembles it into the full key register that drives the scheduler key input.
- Issues the one-cycle schedule trigger, then counts the scheduler's expansion cycles and flags when the round-key vector is stable for the cipher datapath.

Parameters:
- NB_BYTE, 8, bits per byte.
- N_BYTES_KEY, 32, cipher key bytes.
- NB_DATA, 32, input word width; must divide N_BYTES_KEY*NB_BYTE.
- N_ROUNDS, 14, AES rounds; informational, used for the latency default.
- SCHED_LATENCY, N_ROUNDS-1 (13), i_valid cycles the scheduler needs after the trigger until the vector is final.

Ports:
- i_clock  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  global clock enable; no state changes while low.
- i_data  in  NB_DATA  key word, most significant word first.
- i_data_valid  in  1  key word present.
- o_data_ready  out  1  loader accepts a word.
- i_flush  in  1  synchronous abort of load or schedule.
- o_key  out  N_BYTES_KEY*NB_BYTE  assembled key, to scheduler i_key.
- o_trigger_schedule  out  1  to scheduler i_trigger_schedule.
- o_keys_ready  out  1  round-key vector valid.
- o_busy  out  1  high in TRIGGER or WAIT.

Behaviour:
- N_KEY_WORDS = N_BYTES_KEY*NB_BYTE/NB_DATA (8).
- Accept condition: accept = i_valid & i_data_valid & o_data_ready.
- o_data_ready is combinational from state only (LOAD or DONE). It never depends on i_data_valid.
- Key assembly: each accept shifts o_key left by NB_DATA and inserts i_data at the LSBs. After 8 accepts, the first word sits in bits [255:224].
- Word counter: 0..N_KEY_WORDS-1, wraps to 0 on the last accept.
- FSM states:
  - LOAD: accepts words. The last accept moves to TRIGGER.
  - TRIGGER: o_trigger_schedule=1 (Moore output). Moves to WAIT on the first cycle with i_valid=1. The pulse is held across i_valid-low cycles so the scheduler always samples it with i_valid.
  - WAIT: wait counter cleared on entry; increments on each i_valid cycle. Moves to DONE on the SCHED_LATENCY-th increment.
  - DONE: o_keys_ready=1, o_data_ready=1. A first accept moves to LOAD with count=1.
- o_keys_ready:
  - Set on DONE entry.
  - Stays high through a following LOAD, because the scheduler keeps its vector until re-triggered.
  - Cleared on the TRIGGER->WAIT transition or on flush during TRIGGER/WAIT.
- o_key never changes in TRIGGER or WAIT, since no accepts happen there.
- Latency with i_valid=1 constant: last accept in cycle t -> trigger high in t+1 -> WAIT t+2..t+14 -> o_keys_ready=1 from t+15.
- i_flush (gated by i_valid, priority over accept):
  - Any state -> LOAD, word count 0.
  - In TRIGGER/WAIT: o_keys_ready=0.
  - In LOAD/DONE: o_keys_ready unchanged.
  - o_key retained.
- Simultaneous i_flush and accept: the word is dropped, o_key is not shifted, count is 0.
- Reset values: state LOAD, counts 0, o_key 0, o_trigger_schedule 0, o_keys_ready 0, o_busy 0, o_data_ready 1.
- Reset assertion mid-operation: all registers clear asynchronously. Deassertion is synchronised externally.

Optional Feature:
- Macro: KEY_LOADER_ZEROIZE_EN.
- Defined: a flush, and entry to LOAD from DONE via an accept, first clears o_key to 0 before shifting. Partial or old key material never persists on o_key.
  - On a DONE accept, o_key becomes {0..., i_data}.
  - On a flush, o_key becomes 0.
- Undefined: o_key is never cleared except by reset.

Test Plan:
- Reset, then 8 words 0x00010203 .. 0x1C1D1E1F with i_valid=1 -> o_key=0x000102..1F; trigger high exactly at t+1; o_busy t+1..t+14; o_keys_ready=1 at t+15; scheduler round key 14 matches the FIPS-197 AES-256 vector.
- i_valid toggled 1/0 every cycle during load and WAIT -> no state change on low cycles; trigger held until a high cycle; o_keys_ready after exactly 13 high cycles of WAIT.
- i_data_valid held high during TRIGGER/WAIT -> o_data_ready=0, o_key unchanged, no words lost or duplicated when DONE is reached.
- In DONE, reload 8 new words -> o_keys_ready stays 1 until the TRIGGER->WAIT cycle, then 0 for 13 cycles, then 1.
- i_flush after 5 words, then 8 fresh words -> o_key equals only the 8 fresh words. With KEY_LOADER_ZEROIZE_EN, o_key=0 the cycle after the flush.
- i_reset_n asserted mid-WAIT (asynchronously, between edges) -> outputs cleared immediately; after release, o_data_ready=1 and o_keys_ready=0.
